// File: rtl/spm_read_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spm_read_collector_pkg
// Brief    : Shared sizes and types for the scratchpad read-return path.
// Revision : 1.0  initial release
// ============================================================================
package spm_read_collector_pkg;

  // Lane count and bank count of the scratchpad
  localparam int SM_PROCESSING_ELEMENTS = 16;
  localparam int SM_MEMORY_BANKS        = 16;
  localparam int SM_BANK_ADDR_W         = $clog2(SM_MEMORY_BANKS);

  typedef logic [SM_BANK_ADDR_W-1:0] sm_bank_address_t;
  typedef logic [31:0]               sm_data_t;

  // Completion state: gathering passes, or holding a finished result
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } sm_collect_state_t;

endpackage
`default_nettype wire

// File: rtl/spm_read_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : spm_read_collector_if
// Brief    : Pass-issue, bank-return and result handshake bundle for the
//            scratchpad read collector.
// Revision : 1.0  initial release
// ============================================================================
interface spm_read_collector_if;
  import spm_read_collector_pkg::*;

  // Pass issue from the request-side steering
  logic                                             pass_valid;
  logic [SM_PROCESSING_ELEMENTS-1:0]                pass_lane_mask;
  sm_bank_address_t [SM_PROCESSING_ELEMENTS-1:0]    pass_bank_indexes;
  logic                                             pass_last;
  logic                                             pass_is_store;
  logic                                             busy;

  // Bank array outputs, one cycle after the pass
  sm_data_t [SM_MEMORY_BANKS-1:0]                   bank_read_data;

  // Reassembled result towards the consumer
  logic                                             out_valid;
  sm_data_t [SM_PROCESSING_ELEMENTS-1:0]            out_data;
  logic [SM_PROCESSING_ELEMENTS-1:0]                out_mask;
  logic                                             out_is_store;
  logic                                             out_ready;

  // Upstream / consumer side
  modport master (
    output pass_valid, pass_lane_mask, pass_bank_indexes, pass_last,
           pass_is_store, bank_read_data, out_ready,
    input  busy, out_valid, out_data, out_mask, out_is_store
  );

  // Collector side
  modport slave (
    input  pass_valid, pass_lane_mask, pass_bank_indexes, pass_last,
           pass_is_store, bank_read_data, out_ready,
    output busy, out_valid, out_data, out_mask, out_is_store
  );

endinterface
`default_nettype wire

// File: rtl/spm_read_collector_bank_to_lane_mux.sv
`default_nettype none
// ============================================================================
// Module   : bank_to_lane_mux
// Brief    : Combinational B-to-1 select of one bank's read data for a lane.
// Revision : 1.0  initial release
// ============================================================================
module bank_to_lane_mux
  import spm_read_collector_pkg::*;
(
  input  wire sm_data_t [SM_MEMORY_BANKS-1:0] i_bank_data,
  input  wire sm_bank_address_t               i_sel,
  output sm_data_t                            o_data
);

  // Bank index width covers exactly the bank count, so every select is valid
  assign o_data = i_bank_data[i_sel];

endmodule
`default_nettype wire

// File: rtl/spm_read_collector.sv
`default_nettype none
// ============================================================================
// Module   : spm_read_collector
// Brief    : Gathers per-bank read data of one or more conflict-free bank
//            passes into a single lane-ordered result with valid/ready output.
// Revision : 1.0  initial release
// ============================================================================
module spm_read_collector
  import spm_read_collector_pkg::*;
(
  input wire                  clk,
  input wire                  reset,   // asynchronous, active-low
  spm_read_collector_if.slave bus
);

  localparam int N = SM_PROCESSING_ELEMENTS;

  // S1 pass capture
  logic                         s1_valid_q, s1_valid_d;
  logic [N-1:0]                 s1_mask_q, s1_mask_d;
  sm_bank_address_t [N-1:0]     s1_bank_q, s1_bank_d;
  logic                         s1_last_q, s1_last_d;
  logic                         s1_store_q, s1_store_d;

  // Accumulator and completion state
  logic [N-1:0]                 acc_mask_q, acc_mask_d;
  sm_data_t [N-1:0]             acc_data_q, acc_data_d;
  logic                         out_is_store_q, out_is_store_d;
  sm_collect_state_t            state_q, state_d;

  sm_data_t [N-1:0]             w_gathered;
  logic                         w_out_valid;
  logic                         w_handshake;
  logic                         w_busy;
  logic                         w_accept;
  logic                         w_merge;

  assign w_out_valid = (state_q == DONE);
  assign w_handshake = w_out_valid & bus.out_ready;
  // A finished-but-unconsumed result or a last pass in flight blocks new passes
  assign w_busy      = (w_out_valid & ~bus.out_ready) | (s1_valid_q & s1_last_q);
  assign w_accept    = bus.pass_valid & ~w_busy;
  // Only merge while collecting so a held result never changes
  assign w_merge     = s1_valid_q & (state_q == COLLECT);

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane_mux
      bank_to_lane_mux u_mux (
        .i_bank_data (bus.bank_read_data),
        .i_sel       (s1_bank_q[i]),
        .o_data      (w_gathered[i])
      );
    end
  endgenerate

  // Capture an accepted pass; its bank data arrives in the next cycle
  always_comb begin
    s1_valid_d = w_accept;
    s1_mask_d  = s1_mask_q;
    s1_bank_d  = s1_bank_q;
    s1_last_d  = s1_last_q;
    s1_store_d = s1_store_q;
    if (w_accept) begin
      s1_mask_d  = bus.pass_lane_mask;
      s1_bank_d  = bus.pass_bank_indexes;
      s1_last_d  = bus.pass_last;
      s1_store_d = bus.pass_is_store;
    end
  end

  // Completion FSM and accumulator: clear on handshake first, then merge S2
  always_comb begin
    state_d        = state_q;
    acc_mask_d     = acc_mask_q;
    acc_data_d     = acc_data_q;
    out_is_store_d = out_is_store_q;
    if (w_handshake) begin
      state_d        = COLLECT;
      acc_mask_d     = '0;
      acc_data_d     = '0;
      out_is_store_d = 1'b0;
    end
    if (w_merge) begin
      acc_mask_d = acc_mask_d | s1_mask_q;
      for (int i = 0; i < N; i++) begin
        if (s1_mask_q[i] && !s1_store_q) begin
          acc_data_d[i] = w_gathered[i];
        end
      end
      if (s1_last_q) begin
        state_d        = DONE;
        out_is_store_d = s1_store_q;
      end
    end
  end

  // State registers; reset drops any partially collected access at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q     <= 1'b0;
      s1_mask_q      <= '0;
      s1_bank_q      <= '0;
      s1_last_q      <= 1'b0;
      s1_store_q     <= 1'b0;
      acc_mask_q     <= '0;
      acc_data_q     <= '0;
      out_is_store_q <= 1'b0;
      state_q        <= COLLECT;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_mask_q      <= s1_mask_d;
      s1_bank_q      <= s1_bank_d;
      s1_last_q      <= s1_last_d;
      s1_store_q     <= s1_store_d;
      acc_mask_q     <= acc_mask_d;
      acc_data_q     <= acc_data_d;
      out_is_store_q <= out_is_store_d;
      state_q        <= state_d;
    end
  end

  assign bus.busy         = w_busy;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_data     = acc_data_q;
  assign bus.out_mask     = acc_mask_q;
  assign bus.out_is_store = out_is_store_q;

  // Protocol monitors: dropped pass and lane served twice in one access
  a_no_pass_while_busy : assert property (@(posedge clk) disable iff (!reset)
    !(bus.pass_valid && w_busy))
    else $warning("pass_valid while busy: pass dropped");

  a_no_lane_overlap : assert property (@(posedge clk) disable iff (!reset)
    !(w_merge && |(s1_mask_q & acc_mask_q)))
    else $warning("lane served by two passes of one access");

endmodule
`default_nettype wire

// File: tb/tb_spm_read_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_spm_read_collector
// Brief    : Scoreboard bench for the scratchpad read collector.
// Revision : 1.0  initial release
// ============================================================================
module tb_spm_read_collector;
  import spm_read_collector_pkg::*;

  localparam int N = SM_PROCESSING_ELEMENTS;
  localparam int B = SM_MEMORY_BANKS;

  typedef struct {
    sm_data_t [N-1:0] data;
    logic [N-1:0]     mask;
    logic             is_store;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spm_read_collector_if u_if ();

  spm_read_collector u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  sm_bank_address_t [N-1:0] ident;
  sm_bank_address_t [N-1:0] banks;
  exp_t e;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pass(input logic [N-1:0] mask, input sm_bank_address_t [N-1:0] bk,
                            input logic last, input logic store);
    u_if.pass_valid        = 1'b1;
    u_if.pass_lane_mask    = mask;
    u_if.pass_bank_indexes = bk;
    u_if.pass_last         = last;
    u_if.pass_is_store     = store;
  endtask

  task automatic idle_pass();
    u_if.pass_valid     = 1'b0;
    u_if.pass_lane_mask = '0;
    u_if.pass_last      = 1'b0;
    u_if.pass_is_store  = 1'b0;
  endtask

  task automatic fill_banks(input logic [31:0] base);
    for (int b = 0; b < B; b++) u_if.bank_read_data[b] = base + b;
  endtask

  function automatic exp_t blank_exp();
    exp_t x;
    x.data     = '0;
    x.mask     = '0;
    x.is_store = 1'b0;
    return x;
  endfunction

  // Consumer side: every accepted result is compared against the oldest entry
  always @(negedge clk) begin
    if (reset === 1'b1 && u_if.out_valid === 1'b1 && u_if.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("sb_underflow", 32'(u_if.out_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_val("res_mask", 32'(u_if.out_mask), 32'(mon_e.mask));
        check_val("res_store", 32'(u_if.out_is_store), 32'(mon_e.is_store));
        if (!mon_e.is_store) begin
          for (int i = 0; i < N; i++)
            check_val($sformatf("res_lane%0d", i), u_if.out_data[i], mon_e.data[i]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) ident[i] = sm_bank_address_t'(i);
    reset = 1'b1;
    u_if.out_ready = 1'b0;
    u_if.pass_bank_indexes = '0;
    idle_pass();
    fill_banks(32'hDEAD_0000);
    #2 reset = 1'b0;
    repeat (3) tick();

    // Reset state
    check_val("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    check_val("rst_busy", 32'(u_if.busy), 32'd0);
    check_val("rst_out_mask", 32'(u_if.out_mask), 32'd0);
    check_val("rst_out_store", 32'(u_if.out_is_store), 32'd0);
    check_val("rst_out_data0", u_if.out_data[0], 32'd0);
    reset = 1'b1;
    tick();

    // Single-pass load across all lanes
    u_if.out_ready = 1'b1;
    drive_pass(16'hFFFF, ident, 1'b1, 1'b0);
    e = blank_exp();
    e.mask = 16'hFFFF;
    for (int i = 0; i < N; i++) e.data[i] = 32'hA000_0000 + i;
    sb.push_back(e);
    tick();
    idle_pass();
    fill_banks(32'hA000_0000);
    check_val("t1_valid_t1", 32'(u_if.out_valid), 32'd0);
    tick();
    fill_banks(32'hDEAD_0000);
    check_val("t1_valid_t2", 32'(u_if.out_valid), 32'd1);
    tick();
    check_val("t1_cleared", 32'(u_if.out_valid), 32'd0);

    // Two-pass bank conflict: lanes 0 and 1 both on bank 3
    banks = '0;
    banks[0] = 4'd3;
    banks[1] = 4'd3;
    drive_pass(16'h0001, banks, 1'b0, 1'b0);
    tick();
    drive_pass(16'h0002, banks, 1'b1, 1'b0);
    u_if.bank_read_data[3] = 32'h11;
    e = blank_exp();
    e.mask = 16'h0003;
    e.data[0] = 32'h11;
    e.data[1] = 32'h22;
    sb.push_back(e);
    tick();
    idle_pass();
    u_if.bank_read_data[3] = 32'h22;
    check_val("t2_valid_t2", 32'(u_if.out_valid), 32'd0);
    tick();
    fill_banks(32'hDEAD_0000);
    check_val("t2_valid_t3", 32'(u_if.out_valid), 32'd1);
    tick();

    // Backpressure with an illegal pass attempted while busy
    u_if.out_ready = 1'b0;
    for (int i = 0; i < N; i++) banks[i] = sm_bank_address_t'(N - 1 - i);
    drive_pass(16'h00FF, banks, 1'b1, 1'b0);
    e = blank_exp();
    e.mask = 16'h00FF;
    for (int i = 0; i < 8; i++) e.data[i] = 32'hB000_0000 + (N - 1 - i);
    sb.push_back(e);
    tick();
    idle_pass();
    fill_banks(32'hB000_0000);
    tick();
    fill_banks(32'hC000_0000);
    check_val("t3_valid", 32'(u_if.out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check_val("t3_busy", 32'(u_if.busy), 32'd1);
      check_val("t3_hold_valid", 32'(u_if.out_valid), 32'd1);
      check_val("t3_hold_mask", 32'(u_if.out_mask), 32'h00FF);
      check_val("t3_hold_store", 32'(u_if.out_is_store), 32'd0);
      check_val("t3_hold_lane0", u_if.out_data[0], 32'hB000_000F);
      check_val("t3_hold_lane7", u_if.out_data[7], 32'hB000_0008);
      check_val("t3_hold_lane8", u_if.out_data[8], 32'd0);
      if (k == 2) drive_pass(16'hFFFF, ident, 1'b1, 1'b1);
      else idle_pass();
      tick();
    end
    idle_pass();
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
    check_val("t3_rel_valid", 32'(u_if.out_valid), 32'd0);
    check_val("t3_rel_mask", 32'(u_if.out_mask), 32'd0);
    check_val("t3_rel_busy", 32'(u_if.busy), 32'd0);
    tick();

    // Store access: mask reported, flag set, data ignored
    u_if.out_ready = 1'b1;
    drive_pass(16'h00F0, ident, 1'b1, 1'b1);
    e = blank_exp();
    e.mask = 16'h00F0;
    e.is_store = 1'b1;
    sb.push_back(e);
    tick();
    idle_pass();
    fill_banks(32'hE000_0000);
    tick();
    fill_banks(32'hDEAD_0000);
    check_val("t4_valid", 32'(u_if.out_valid), 32'd1);
    check_val("t4_store", 32'(u_if.out_is_store), 32'd1);
    tick();
    check_val("t4_store_clr", 32'(u_if.out_is_store), 32'd0);

    // Empty last pass completes with no lanes
    drive_pass(16'h0000, ident, 1'b1, 1'b0);
    sb.push_back(blank_exp());
    tick();
    idle_pass();
    tick();
    check_val("t5_valid", 32'(u_if.out_valid), 32'd1);
    tick();

    // Reset after the first of two passes has merged
    drive_pass(16'h000F, ident, 1'b0, 1'b0);
    tick();
    idle_pass();
    fill_banks(32'h5000_0000);
    tick();
    fill_banks(32'hDEAD_0000);
    check_val("t6_partial_mask", 32'(u_if.out_mask), 32'h000F);
    reset = 1'b0;
    #1;
    check_val("t6_rst_mask", 32'(u_if.out_mask), 32'd0);
    check_val("t6_rst_lane0", u_if.out_data[0], 32'd0);
    check_val("t6_rst_valid", 32'(u_if.out_valid), 32'd0);
    check_val("t6_rst_busy", 32'(u_if.busy), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    drive_pass(16'h0030, ident, 1'b1, 1'b0);
    e = blank_exp();
    e.mask = 16'h0030;
    e.data[4] = 32'h6000_0004;
    e.data[5] = 32'h6000_0005;
    sb.push_back(e);
    tick();
    idle_pass();
    fill_banks(32'h6000_0000);
    check_val("t6_fresh_t1", 32'(u_if.out_valid), 32'd0);
    tick();
    fill_banks(32'hDEAD_0000);
    check_val("t6_fresh_t2", 32'(u_if.out_valid), 32'd1);
    repeat (3) tick();

    check_val("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
